rgb_stream_arbiter: RTL

// - Packet-level arbiter in front of the first-match RGB pixel select mux.
// - NUM_INPUTS ready/valid RGB pixel streams compete for one output stream.
// - Arbitration is round-robin or fixed-priority; a winning input holds its grant until its in_last beat.
// - Exports a one-hot grant that drives the mux select, plus a registered, handshaked output pixel.

---
 rtl/rgb_stream_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 37 +++
 rtl/rgb_stream_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rgb_stream_pkg.sv
// Shared types for the RGB stream arbiter.
// Pixel bundle, arbiter state and one-hot helper.
package rgb_stream_pkg;

  localparam int MAX_INPUTS  = 32;
  localparam int PIXEL_WIDTH = 8;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] r;
    logic [PIXEL_WIDTH-1:0] g;
    logic [PIXEL_WIDTH-1:0] b;
  } rgb_pixel_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  function automatic logic [MAX_INPUTS-1:0] onehot(
    input int unsigned index
  );
    logic [MAX_INPUTS-1:0] v;
    v = MAX_INPUTS'(1) << index;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection for the stream arbiter.
// Round-robin scans from ptr+1 with wrap; fixed mode picks the lowest index.
module rr_priority_picker
  import rgb_stream_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IW-1:0]         ptr,
  input  logic                  rr_mode,
  output logic [NUM_INPUTS-1:0] winner,
  output logic [IW-1:0]         index,
  output logic                  found
);

  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    index  = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (rr_mode) begin
        j = (int'(ptr) + 1 + k) % NUM_INPUTS;
      end else begin
        j = k;
      end
      if (!found && req[j]) begin
        found  = 1'b1;
        winner = NUM_INPUTS'(onehot(j));
        index  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rgb_stream_arbiter.sv
// Packet-level arbiter for N ready/valid RGB streams.
// The owner keeps its grant until its last beat; output is one register deep.
module rgb_stream_arbiter
  import rgb_stream_pkg::*;
#(
  parameter int NUM_INPUTS    = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter bit ROUND_ROBIN   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS-1:0]               in_last,
  input  logic [NUM_INPUTS*CHANNEL_WIDTH-1:0] in_r,
  input  logic [NUM_INPUTS*CHANNEL_WIDTH-1:0] in_g,
  input  logic [NUM_INPUTS*CHANNEL_WIDTH-1:0] in_b,
  output logic [NUM_INPUTS-1:0]               grant,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic [CHANNEL_WIDTH-1:0]            out_r,
  output logic [CHANNEL_WIDTH-1:0]            out_g,
  output logic [CHANNEL_WIDTH-1:0]            out_b
);

  localparam int N  = NUM_INPUTS;
  localparam int W  = CHANNEL_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

  logic          can_accept;
  logic          sel_valid;
  logic          sel_last;
  logic [W-1:0]  sel_r;
  logic [W-1:0]  sel_g;
  logic [W-1:0]  sel_b;
  logic          xfer;

  rr_priority_picker #(
    .NUM_INPUTS (N),
    .IW         (IW)
  ) u_picker (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .rr_mode (ROUND_ROBIN),
    .winner  (pick_gnt),
    .index   (pick_idx),
    .found   (pick_found)
  );

  assign can_accept = ~out_valid | out_ready;
  // grant is all-zero in IDLE, so this also holds in_ready low there
  assign in_ready   = grant & {N{can_accept}};

  // One-hot AND-OR select, same result as the downstream first-match mux
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_r     = '0;
    sel_g     = '0;
    sel_b     = '0;
    for (int i = 0; i < N; i++) begin
      sel_valid = sel_valid | (in_valid[i] & grant[i]);
      sel_last  = sel_last | (in_last[i] & grant[i]);
      sel_r     = sel_r | (in_r[i*W +: W] & {W{grant[i]}});
      sel_g     = sel_g | (in_g[i*W +: W] & {W{grant[i]}});
      sel_b     = sel_b | (in_b[i*W +: W] & {W{grant[i]}});
    end
  end

  assign xfer = (state == LOCKED) & sel_valid & can_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= IW'(N - 1);
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_last  <= sel_last;
        out_r     <= sel_r;
        out_g     <= sel_g;
        out_b     <= sel_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_gnt;
            owner <= pick_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            grant  <= '0;
            rr_ptr <= owner;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
